// File: rtl/ant_pkg.sv
// Shared definitions for the ant navigation and motion blocks.
// Holds heading codes, motion/navigation state encodings, turn-command
// encodings and the heading rotation helper.
package ant_pkg;

    // Compass headings, clockwise order so a right turn is +1 mod 4.
    typedef enum logic [1:0] {
        HEAD_N = 2'b00,
        HEAD_E = 2'b01,
        HEAD_S = 2'b10,
        HEAD_W = 2'b11
    } heading_t;

    // Motion sequencer states.
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_TURN = 2'b01,
        S_MOVE = 2'b10,
        S_DONE = 2'b11
    } motionState_t;

    // Turn request formed as {TLeft, TRight}.
    typedef enum logic [1:0] {
        TURN_NONE  = 2'b00,
        TURN_RIGHT = 2'b01,
        TURN_LEFT  = 2'b10,
        TURN_BOTH  = 2'b11
    } turnCmd_t;

    // Navigation FSM states (upstream block).
    typedef enum logic [2:0] {
        NAV_LOST    = 3'd0,
        NAV_ROTATE  = 3'd1,
        NAV_WALL    = 3'd2,
        NAV_TRACK_L = 3'd3,
        NAV_TRACK_R = 3'd4,
        NAV_GOAL    = 3'd5
    } navState_t;

    // Command set latched when a step is accepted.
    typedef struct packed {
        logic fw;
        logic tLeft;
        logic tRight;
    } moveCmd_t;

    // New heading after applying a turn command; a conflicting command leaves it unchanged.
    function automatic logic [1:0] turnHeading(input logic [1:0] h, input turnCmd_t t);
        case (t)
            TURN_LEFT:  return h - 2'd1;
            TURN_RIGHT: return h + 2'd1;
            default:    return h;
        endcase
    endfunction

endpackage

// File: rtl/ant_sat_counter.sv
// Saturating up-counter with enable and asynchronous active-low reset.
module ant_sat_counter #(
    parameter int W = 16
) (
    input  logic         CLK,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] count
);

    // Count enabled events, sticking at all-ones.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/ant_motion.sv
// Ant motion sequencer: executes one {FW, TLeft, TRight} command set per
// accepted step (turn, then move, then done) and tracks grid position.
// Define ANT_MOTION_WRAP_EN to make grid edges wrap instead of clamp-and-bump.
module ant_motion
    import ant_pkg::*;
#(
    parameter int         X_W        = 5,
    parameter int         Y_W        = 5,
    parameter int         X_MAX      = 31,
    parameter int         Y_MAX      = 31,
    parameter int         X_START    = 0,
    parameter int         Y_START    = 0,
    parameter logic [1:0] HEAD_START = 2'b01
) (
    input  logic           CLK,
    input  logic           reset,
    input  logic           stepEn,
    input  logic           FW,
    input  logic           TLeft,
    input  logic           TRight,
    output logic [X_W-1:0] xPos,
    output logic [Y_W-1:0] yPos,
    output logic [1:0]     heading,
    output logic           busy,
    output logic           stepDone,
    output logic           bump,
    output logic           cmdErr,
    output logic           overrun,
    output logic [15:0]    moveCount
);

`ifdef ANT_MOTION_WRAP_EN
    localparam logic WRAP = 1'b1;
`else
    localparam logic WRAP = 1'b0;
`endif

    localparam logic [X_W-1:0] X_LIM = X_W'(X_MAX);
    localparam logic [Y_W-1:0] Y_LIM = Y_W'(Y_MAX);
    localparam logic [X_W-1:0] X_INI = X_W'(X_START);
    localparam logic [Y_W-1:0] Y_INI = Y_W'(Y_START);

    motionState_t   state, stateNext;
    moveCmd_t       cmdReg, cmdNext;
    logic [X_W-1:0] xNext, xStep;
    logic [Y_W-1:0] yNext, yStep;
    logic [1:0]     headNext;
    logic           busyNext, stepDoneNext, bumpNext, cmdErrNext, overrunNext;
    logic           edgeHit, blocked, moveEn;

    // Target cell one step along the current heading; at an edge either wrap or hold.
    always_comb begin
        xStep   = xPos;
        yStep   = yPos;
        edgeHit = 1'b0;
        case (heading)
            HEAD_N: begin
                if (yPos == '0) begin
                    edgeHit = 1'b1;
                    yStep   = WRAP ? Y_LIM : yPos;
                end else begin
                    yStep = yPos - 1'b1;
                end
            end
            HEAD_S: begin
                if (yPos == Y_LIM) begin
                    edgeHit = 1'b1;
                    yStep   = WRAP ? '0 : yPos;
                end else begin
                    yStep = yPos + 1'b1;
                end
            end
            HEAD_E: begin
                if (xPos == X_LIM) begin
                    edgeHit = 1'b1;
                    xStep   = WRAP ? '0 : xPos;
                end else begin
                    xStep = xPos + 1'b1;
                end
            end
            default: begin
                if (xPos == '0) begin
                    edgeHit = 1'b1;
                    xStep   = WRAP ? X_LIM : xPos;
                end else begin
                    xStep = xPos - 1'b1;
                end
            end
        endcase
        blocked = edgeHit & ~WRAP;
    end

    // Next-state and next-output logic for the step sequencer.
    always_comb begin
        stateNext    = state;
        cmdNext      = cmdReg;
        headNext     = heading;
        xNext        = xPos;
        yNext        = yPos;
        busyNext     = busy;
        stepDoneNext = 1'b0;
        bumpNext     = 1'b0;
        cmdErrNext   = cmdErr;
        overrunNext  = overrun;
        moveEn       = 1'b0;

        if (stepEn && (state != S_IDLE)) begin
            overrunNext = 1'b1;
        end

        case (state)
            S_IDLE: begin
                if (stepEn) begin
                    cmdNext   = '{fw: FW, tLeft: TLeft, tRight: TRight};
                    stateNext = S_TURN;
                    busyNext  = 1'b1;
                end
            end
            S_TURN: begin
                headNext = turnHeading(heading, turnCmd_t'({cmdReg.tLeft, cmdReg.tRight}));
                if (cmdReg.tLeft && cmdReg.tRight) begin
                    cmdErrNext = 1'b1;
                end
                stateNext = S_MOVE;
            end
            S_MOVE: begin
                if (cmdReg.fw) begin
                    xNext    = xStep;
                    yNext    = yStep;
                    bumpNext = blocked;
                    moveEn   = ~blocked;
                end
                stepDoneNext = 1'b1;
                stateNext    = S_DONE;
            end
            S_DONE: begin
                stateNext = S_IDLE;
                busyNext  = 1'b0;
            end
            default: begin
                stateNext = S_IDLE;
                busyNext  = 1'b0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            cmdReg   <= '0;
            xPos     <= X_INI;
            yPos     <= Y_INI;
            heading  <= HEAD_START;
            busy     <= 1'b0;
            stepDone <= 1'b0;
            bump     <= 1'b0;
            cmdErr   <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            state    <= stateNext;
            cmdReg   <= cmdNext;
            xPos     <= xNext;
            yPos     <= yNext;
            heading  <= headNext;
            busy     <= busyNext;
            stepDone <= stepDoneNext;
            bump     <= bumpNext;
            cmdErr   <= cmdErrNext;
            overrun  <= overrunNext;
        end
    end

    ant_sat_counter #(
        .W(16)
    ) uMoveCount (
        .CLK  (CLK),
        .reset(reset),
        .en   (moveEn),
        .count(moveCount)
    );

endmodule
